hit_detect_scanner: RTL
=======================

// Module: hit_detect_scanner
// PURPOSE
//  Collision/cull stage downstream of the bullet generate-and-move stage. Takes a frame snapshot of enemy,
//  player and bullet state/positions. Scans it sequentially, one bullet per cycle, and returns kill/clear
//  masks. The upstream stage applies those masks on its next update.
//  Position format everywhere: 19 bits {x[18:9] (10b), y[8:0] (9b)}, top-left corner of the sprite.
// PARAMETERS
//  MAX_ENEMY          15   enemy slots
//  MAX_PLAYER_BULLET  15   player bullet slots
//  MAX_ENEMY_BULLET   31   enemy bullet slots
//  SCREEN_H           480  y >= SCREEN_H is off-screen (also catches 9-bit wrap of y below 0)
//  ENEMY_W/ENEMY_H    32/24; PLAYER_W/PLAYER_H 20/16; BULLET_W/BULLET_H 4/8 (sprite boxes, pixels)
// PORTS
//  i_Clk                in   1                       clock
//  i_Rst                in   1                       asynchronous reset, active-low
//  i_fStart             in   1                       frame tick: snapshot inputs and begin scan
//  i_PlayerState        in   1                       1 = player alive
//  i_PlayerPosition     in   19                      player position
//  i_EnemyState         in   MAX_ENEMY               1 = enemy alive, bit i = slot i
//  i_EnemyPosition      in   19*MAX_ENEMY            slot i at [19*i+:19]
//  i_PlayerBulletState  in   MAX_PLAYER_BULLET       1 = bullet exists
//  i_PlayerBulletPos    in   19*MAX_PLAYER_BULLET    slot i at [19*i+:19]
//  i_EnemyBulletState   in   MAX_ENEMY_BULLET        1 = bullet exists
//  i_EnemyBulletPos     in   19*MAX_ENEMY_BULLET     slot i at [19*i+:19]
//  o_Busy               out  1                       scan in progress
//  o_fDone              out  1                       1-cycle pulse: output masks valid
//  o_EnemyKill          out  MAX_ENEMY               enemies to clear
//  o_PlayerBulletClear  out  MAX_PLAYER_BULLET       player bullets to clear (hit or off-screen)
//  o_EnemyBulletClear   out  MAX_ENEMY_BULLET        enemy bullets to clear (hit or off-screen)
//  o_PlayerHit          out  1                       player struck this frame
//  o_KillCnt            out  4                       number of enemies killed this frame
// BEHAVIOUR
//  Reset: FSM=IDLE. All outputs 0. Snapshot registers 0.
//  FSM: IDLE -> SCAN_PB -> SCAN_EB -> DONE -> IDLE.
//   IDLE:    on i_fStart, latch every i_* input into snapshot regs, clear all output masks/counters,
//            clear o_PlayerHit, set index=0, go to SCAN_PB.
//   SCAN_PB: one player bullet p per cycle, p = 0..MAX_PLAYER_BULLET-1.
//            If bullet exists and y >= SCREEN_H: set clear[p].
//            Else test its AABB against all enemies alive in the snapshot and not already killed, in parallel.
//            On any overlap, kill only the lowest-index overlapping enemy, set clear[p], and increment o_KillCnt.
//   SCAN_EB: one enemy bullet e per cycle, e = 0..MAX_ENEMY_BULLET-1.
//            If bullet exists and y >= SCREEN_H: set clear[e].
//            Else if the player is alive and the boxes overlap: set clear[e] and set o_PlayerHit (sticky).
//   DONE:    o_fDone=1 for exactly 1 cycle, then IDLE.
//  Timing: i_fStart sampled at edge k. o_Busy=1 from k+1 through the DONE cycle. o_fDone in cycle k+47
//   (1 + MAX_PLAYER_BULLET + MAX_ENEMY_BULLET).
//  Output hold: masks hold their value after DONE until the next accepted i_fStart.
//  Overlap: strict AABB test, ax < bx+bw && bx < ax+aw && ay < by+bh && by < ay+ah.
//   Sums are computed at 11b (x) and 10b (y), so no wrap occurs.
//  Non-existent slots: never flagged.
//  Several enemy bullets may hit the player in one frame: all of them are cleared, o_PlayerHit=1.
//  i_fStart while o_Busy: ignored, no restart.
//  i_fStart in the DONE cycle: ignored.
//  Inputs changing mid-scan: no effect; only the snapshot is used.
//  Reset mid-scan: immediate return to IDLE with all outputs 0. No o_fDone is issued.
// STRUCTURE
//  Shared package (game_pkg.vh): POS_W=19, X/Y field slices, SCREEN_H, all sprite W/H constants, MAX_* counts.
//   The same package is used by the bullet and render stages.
//  Sub-module: aabb_overlap (combinational; params AW,AH,BW,BH; in posA,posB; out hit).
//   Instantiate MAX_ENEMY copies for the player-bullet vs enemy test and 1 copy for enemy-bullet vs player.
//  Lowest-index enemy selection: priority encoder inside this module.
// TESTING
//  1 Reset held, then released, with no start -> all outputs 0, o_Busy=0.
//  2 Enemy slot 0 at (100,50) alive; player bullet 3 at (110,60), start
//    -> at k+47 o_fDone=1, o_EnemyKill=0x0001, o_PlayerBulletClear=0x0008, o_KillCnt=1.
//  3 Enemies 2 and 5 both at (200,100); player bullet 0 at (210,110)
//    -> o_EnemyKill bit 2 only, o_KillCnt=1.
//    Add player bullet 1 at the same spot -> bits 2 and 5 killed, o_KillCnt=2.
//  4 Player at (300,440) alive; enemy bullets 0 and 30 at (305,445); enemy bullet 7 at y=480
//    -> o_PlayerHit=1, o_EnemyBulletClear=0x4000_0081.
//    Same frame with i_PlayerState=0 -> o_PlayerHit=0, clear=0x0000_0080.
//  5 Player bullet 4 at y=511 (wrapped) -> clear bit 4, no kill.
//    Edge-touching boxes (bx = ax+aw) -> no hit.
//  6 i_fStart pulsed at k+10 and k+47 -> ignored both times, single o_fDone.
//    Assert i_Rst at k+20 -> outputs 0, o_Busy=0, no o_fDone.

Source files
------------

// File: rtl/hit_detect_scanner_pkg.sv
// Shared game constants: position format, screen limits, sprite sizes, slot counts.
package hit_detect_scanner_pkg;

  localparam int unsigned POS_W = 19;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned X_LSB = 9;

  localparam int unsigned MAX_ENEMY         = 15;
  localparam int unsigned MAX_PLAYER_BULLET = 15;
  localparam int unsigned MAX_ENEMY_BULLET  = 31;

  localparam int unsigned PB_IDX_W = $clog2(MAX_PLAYER_BULLET);
  localparam int unsigned EB_IDX_W = $clog2(MAX_ENEMY_BULLET);

  localparam int unsigned SCREEN_H = 480;
  localparam logic [Y_W-1:0] SCREEN_H_Y = Y_W'(SCREEN_H);

  localparam int unsigned ENEMY_W  = 32;
  localparam int unsigned ENEMY_H  = 24;
  localparam int unsigned PLAYER_W = 20;
  localparam int unsigned PLAYER_H = 16;
  localparam int unsigned BULLET_W = 4;
  localparam int unsigned BULLET_H = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN_PB,
    ST_SCAN_EB,
    ST_DONE
  } scan_state_t;

  function automatic logic [X_W-1:0] pos_x(input logic [POS_W-1:0] p);
    return p[POS_W-1:X_LSB];
  endfunction

  function automatic logic [Y_W-1:0] pos_y(input logic [POS_W-1:0] p);
    return p[Y_W-1:0];
  endfunction

endpackage

// File: rtl/hit_detect_scanner_aabb_overlap.sv
// Strict axis-aligned box overlap between sprite A and sprite B (top-left positions).
module aabb_overlap
  import hit_detect_scanner_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned AH = 8,
  parameter int unsigned BW = 32,
  parameter int unsigned BH = 24
) (
  input  logic [POS_W-1:0] pos_a,
  input  logic [POS_W-1:0] pos_b,
  output logic             hit
);

  localparam logic [X_W:0] AW_X = (X_W+1)'(AW);
  localparam logic [X_W:0] BW_X = (X_W+1)'(BW);
  localparam logic [Y_W:0] AH_Y = (Y_W+1)'(AH);
  localparam logic [Y_W:0] BH_Y = (Y_W+1)'(BH);

  logic [X_W:0] ax, bx;
  logic [Y_W:0] ay, by;

  // One extra bit on each axis so position+size never wraps.
  always_comb begin
    ax  = {1'b0, pos_x(pos_a)};
    bx  = {1'b0, pos_x(pos_b)};
    ay  = {1'b0, pos_y(pos_a)};
    by  = {1'b0, pos_y(pos_b)};
    hit = (ax < (bx + BW_X)) && (bx < (ax + AW_X)) &&
          (ay < (by + BH_Y)) && (by < (ay + AH_Y));
  end

endmodule

// File: rtl/hit_detect_scanner.sv
// Frame collision/cull scanner: snapshots game state, walks player bullets then
// enemy bullets one per cycle, and produces kill/clear masks for the next update.
module hit_detect_scanner
  import hit_detect_scanner_pkg::*;
(
  input  logic                                i_Clk,
  input  logic                                i_Rst,
  input  logic                                i_fStart,
  input  logic                                i_PlayerState,
  input  logic [POS_W-1:0]                    i_PlayerPosition,
  input  logic [MAX_ENEMY-1:0]                i_EnemyState,
  input  logic [POS_W*MAX_ENEMY-1:0]          i_EnemyPosition,
  input  logic [MAX_PLAYER_BULLET-1:0]        i_PlayerBulletState,
  input  logic [POS_W*MAX_PLAYER_BULLET-1:0]  i_PlayerBulletPos,
  input  logic [MAX_ENEMY_BULLET-1:0]         i_EnemyBulletState,
  input  logic [POS_W*MAX_ENEMY_BULLET-1:0]   i_EnemyBulletPos,
  output logic                                o_Busy,
  output logic                                o_fDone,
  output logic [MAX_ENEMY-1:0]                o_EnemyKill,
  output logic [MAX_PLAYER_BULLET-1:0]        o_PlayerBulletClear,
  output logic [MAX_ENEMY_BULLET-1:0]         o_EnemyBulletClear,
  output logic                                o_PlayerHit,
  output logic [3:0]                          o_KillCnt
);

  scan_state_t state;

  logic                               snap_player_state;
  logic [POS_W-1:0]                   snap_player_pos;
  logic [MAX_ENEMY-1:0]               snap_enemy_state;
  logic [POS_W*MAX_ENEMY-1:0]         snap_enemy_pos;
  logic [MAX_PLAYER_BULLET-1:0]       snap_pb_state;
  logic [POS_W*MAX_PLAYER_BULLET-1:0] snap_pb_pos;
  logic [MAX_ENEMY_BULLET-1:0]        snap_eb_state;
  logic [POS_W*MAX_ENEMY_BULLET-1:0]  snap_eb_pos;

  logic [PB_IDX_W-1:0] pb_idx;
  logic [EB_IDX_W-1:0] eb_idx;

  logic [POS_W-1:0]     pb_pos, eb_pos;
  logic                 pb_exists, pb_off, eb_exists, eb_off;
  logic [MAX_ENEMY-1:0] enemy_overlap, enemy_cand, kill_sel;
  logic                 any_kill, eb_player_overlap;
  logic                 found;

  assign pb_pos = snap_pb_pos[POS_W*pb_idx +: POS_W];
  assign eb_pos = snap_eb_pos[POS_W*eb_idx +: POS_W];

  for (genvar g = 0; g < MAX_ENEMY; g++) begin : g_pb_vs_enemy
    aabb_overlap #(
      .AW(BULLET_W), .AH(BULLET_H), .BW(ENEMY_W), .BH(ENEMY_H)
    ) u_pb_enemy (
      .pos_a(pb_pos),
      .pos_b(snap_enemy_pos[POS_W*g +: POS_W]),
      .hit  (enemy_overlap[g])
    );
  end

  aabb_overlap #(
    .AW(BULLET_W), .AH(BULLET_H), .BW(PLAYER_W), .BH(PLAYER_H)
  ) u_eb_player (
    .pos_a(eb_pos),
    .pos_b(snap_player_pos),
    .hit  (eb_player_overlap)
  );

  // Current-slot classification and lowest-index live-enemy selection.
  always_comb begin
    pb_exists  = snap_pb_state[pb_idx];
    pb_off     = pos_y(pb_pos) >= SCREEN_H_Y;
    eb_exists  = snap_eb_state[eb_idx];
    eb_off     = pos_y(eb_pos) >= SCREEN_H_Y;
    enemy_cand = enemy_overlap & snap_enemy_state & ~o_EnemyKill;
    kill_sel   = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < MAX_ENEMY; i++) begin
      if (enemy_cand[i] && !found) begin
        kill_sel[i] = 1'b1;
        found       = 1'b1;
      end
    end
    any_kill = found;
  end

  // Scan sequencer with registered masks, counters and handshake outputs.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state               <= ST_IDLE;
      pb_idx              <= '0;
      eb_idx              <= '0;
      snap_player_state   <= 1'b0;
      snap_player_pos     <= '0;
      snap_enemy_state    <= '0;
      snap_enemy_pos      <= '0;
      snap_pb_state       <= '0;
      snap_pb_pos         <= '0;
      snap_eb_state       <= '0;
      snap_eb_pos         <= '0;
      o_Busy              <= 1'b0;
      o_fDone             <= 1'b0;
      o_EnemyKill         <= '0;
      o_PlayerBulletClear <= '0;
      o_EnemyBulletClear  <= '0;
      o_PlayerHit         <= 1'b0;
      o_KillCnt           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_fDone <= 1'b0;
          if (i_fStart) begin
            snap_player_state   <= i_PlayerState;
            snap_player_pos     <= i_PlayerPosition;
            snap_enemy_state    <= i_EnemyState;
            snap_enemy_pos      <= i_EnemyPosition;
            snap_pb_state       <= i_PlayerBulletState;
            snap_pb_pos         <= i_PlayerBulletPos;
            snap_eb_state       <= i_EnemyBulletState;
            snap_eb_pos         <= i_EnemyBulletPos;
            o_EnemyKill         <= '0;
            o_PlayerBulletClear <= '0;
            o_EnemyBulletClear  <= '0;
            o_PlayerHit         <= 1'b0;
            o_KillCnt           <= '0;
            pb_idx              <= '0;
            eb_idx              <= '0;
            o_Busy              <= 1'b1;
            state               <= ST_SCAN_PB;
          end
        end
        ST_SCAN_PB: begin
          if (pb_exists) begin
            if (pb_off) begin
              o_PlayerBulletClear[pb_idx] <= 1'b1;
            end else if (any_kill) begin
              o_EnemyKill                 <= o_EnemyKill | kill_sel;
              o_PlayerBulletClear[pb_idx] <= 1'b1;
              o_KillCnt                   <= o_KillCnt + 4'd1;
            end
          end
          if (pb_idx == PB_IDX_W'(MAX_PLAYER_BULLET - 1)) begin
            pb_idx <= '0;
            state  <= ST_SCAN_EB;
          end else begin
            pb_idx <= pb_idx + 1'b1;
          end
        end
        ST_SCAN_EB: begin
          if (eb_exists) begin
            if (eb_off) begin
              o_EnemyBulletClear[eb_idx] <= 1'b1;
            end else if (snap_player_state && eb_player_overlap) begin
              o_EnemyBulletClear[eb_idx] <= 1'b1;
              o_PlayerHit                <= 1'b1;
            end
          end
          if (eb_idx == EB_IDX_W'(MAX_ENEMY_BULLET - 1)) begin
            eb_idx  <= '0;
            o_fDone <= 1'b1;
            state   <= ST_DONE;
          end else begin
            eb_idx <= eb_idx + 1'b1;
          end
        end
        ST_DONE: begin
          o_fDone <= 1'b0;
          o_Busy  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
